data_memory_arbiter: RTL and testbench

- Two-requester arbiter in front of the single-port 1K x 32 data memory.
- Requester A is the CPU load/store (MEM) stage; requester B is a DMA/loader port.
- Drives the memory's Address/WriteData/MemWrite/MemRead, returns registered read data per requester, supports round-robin fairness, B burst lock with bounded hold, and out-of-range address protection.

---
 rtl/data_memory_arbiter_if.sv | 53 +++++
 rtl/data_memory_arbiter.sv | 143 ++++++++++++++
 tb/tb_data_memory_arbiter.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_memory_arbiter_if                                               |
// | Requester A/B buses plus the single-port data memory bus.            |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
interface data_memory_arbiter_if;
  logic        a_req;
  logic        a_write;
  logic [31:0] a_addr;
  logic [31:0] a_wdata;
  logic        a_gnt;
  logic        a_rvalid;
  logic [31:0] a_rdata;

  logic        b_req;
  logic        b_write;
  logic [31:0] b_addr;
  logic [31:0] b_wdata;
  logic        b_lock;
  logic        b_gnt;
  logic        b_rvalid;
  logic [31:0] b_rdata;

  logic        err;

  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_rdata;

  modport slave (
    input  a_req, a_write, a_addr, a_wdata,
    input  b_req, b_write, b_addr, b_wdata, b_lock,
    input  mem_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output err,
    output mem_address, mem_wdata, mem_write, mem_read
  );

  modport master (
    output a_req, a_write, a_addr, a_wdata,
    output b_req, b_write, b_addr, b_wdata, b_lock,
    output mem_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  err,
    input  mem_address, mem_wdata, mem_write, mem_read
  );
endinterface
`default_nettype wire

// File: rtl/data_memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_memory_arbiter                                                  |
// | Round-robin arbiter with B burst lock in front of a 1K x 32 memory.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module data_memory_arbiter #(
  parameter int MEM_BYTES = 4096,
  parameter int LOCK_MAX  = 16
) (
  input  wire logic             clk,
  input  wire logic             rst,
  data_memory_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    LOCK_B  = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [7:0]  lock_cnt;
  logic [7:0]  lock_cnt_next;
  logic [8:0]  cnt_inc;
  logic        last_b;
  logic        last_b_next;

  logic        a_gnt;
  logic        b_gnt;
  logic        any_gnt;
  logic        sel_write;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        in_range;

  logic        a_rvalid_q;
  logic [31:0] a_rdata_q;
  logic        b_rvalid_q;
  logic [31:0] b_rdata_q;
  logic        err_q;

  assign cnt_inc = {1'b0, lock_cnt} + 9'd1;

  always_comb begin
    a_gnt         = 1'b0;
    b_gnt         = 1'b0;
    state_next    = state;
    lock_cnt_next = lock_cnt;
    last_b_next   = last_b;
    case (state)
      ARB: begin
        if (bus.a_req && bus.b_req) begin
          a_gnt = last_b;
          b_gnt = ~last_b;
        end else begin
          a_gnt = bus.a_req;
          b_gnt = bus.b_req;
        end
        if (b_gnt && bus.b_lock) begin
          lock_cnt_next = 8'd1;
          state_next    = (LOCK_MAX == 1) ? RELEASE : LOCK_B;
        end
      end
      LOCK_B: begin
        b_gnt = bus.b_req;
        if (b_gnt) begin
          lock_cnt_next = cnt_inc[7:0];
        end
        // Hitting the hold limit forces the release cycle even if B drops lock now.
        if (b_gnt && (cnt_inc == 9'(LOCK_MAX))) begin
          state_next = RELEASE;
        end else if (!bus.b_lock) begin
          state_next = ARB;
        end
      end
      RELEASE: begin
        a_gnt      = bus.a_req;
        state_next = ARB;
      end
      default: begin
        state_next = ARB;
      end
    endcase
    if (a_gnt) begin
      last_b_next = 1'b0;
    end
    if (b_gnt) begin
      last_b_next = 1'b1;
    end
    if (state == RELEASE) begin
      last_b_next = 1'b1;
    end
  end

  assign any_gnt   = a_gnt | b_gnt;
  assign sel_write = b_gnt ? bus.b_write : bus.a_write;
  assign sel_addr  = b_gnt ? bus.b_addr  : bus.a_addr;
  assign sel_wdata = b_gnt ? bus.b_wdata : bus.a_wdata;
  assign in_range  = (sel_addr < 32'(MEM_BYTES));

  assign bus.mem_address = any_gnt ? sel_addr  : 32'd0;
  assign bus.mem_wdata   = any_gnt ? sel_wdata : 32'd0;
  assign bus.mem_write   = any_gnt &  sel_write & in_range;
  assign bus.mem_read    = any_gnt & ~sel_write & in_range;

  assign bus.a_gnt    = a_gnt;
  assign bus.b_gnt    = b_gnt;
  assign bus.a_rvalid = a_rvalid_q;
  assign bus.a_rdata  = a_rdata_q;
  assign bus.b_rvalid = b_rvalid_q;
  assign bus.b_rdata  = b_rdata_q;
  assign bus.err      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB;
      lock_cnt   <= 8'd0;
      last_b     <= 1'b1;
      a_rvalid_q <= 1'b0;
      a_rdata_q  <= 32'd0;
      b_rvalid_q <= 1'b0;
      b_rdata_q  <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state      <= state_next;
      lock_cnt   <= lock_cnt_next;
      last_b     <= last_b_next;
      a_rvalid_q <= a_gnt & ~bus.a_write;
      b_rvalid_q <= b_gnt & ~bus.b_write;
      err_q      <= any_gnt & ~in_range;
      if (a_gnt && !bus.a_write) begin
        a_rdata_q <= in_range ? bus.mem_rdata : 32'd0;
      end
      if (b_gnt && !bus.b_write) begin
        b_rdata_q <= in_range ? bus.mem_rdata : 32'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_memory_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_memory_arbiter                                               |
// | Directed self-checking bench with a behavioural 1K x 32 memory.      |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_data_memory_arbiter;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [31:0] mem [0:1023] = '{default: 32'h0};

  data_memory_arbiter_if bus();

  data_memory_arbiter #(.MEM_BYTES(4096), .LOCK_MAX(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_address[11:2]];
  always @(posedge clk) begin
    if (bus.mem_write) mem[bus.mem_address[11:2]] <= bus.mem_wdata;
  end

  task automatic set_a(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wd);
    bus.a_req = req; bus.a_write = wr; bus.a_addr = addr; bus.a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic lock);
    bus.b_req = req; bus.b_write = wr; bus.b_addr = addr; bus.b_wdata = wd; bus.b_lock = lock;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    repeat (2) tick();
    total++; if (bus.a_rvalid !== 1'b0) begin bad++; $display("FAIL reset_a_rvalid got=%b want=0", bus.a_rvalid); end
    total++; if (bus.b_rvalid !== 1'b0) begin bad++; $display("FAIL reset_b_rvalid got=%b want=0", bus.b_rvalid); end
    total++; if (bus.err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", bus.err); end
    total++; if (bus.a_rdata !== 32'h0) begin bad++; $display("FAIL reset_a_rdata got=%h want=0", bus.a_rdata); end
    total++; if (bus.b_rdata !== 32'h0) begin bad++; $display("FAIL reset_b_rdata got=%h want=0", bus.b_rdata); end
    total++; if ({bus.mem_write, bus.mem_read, bus.mem_address} !== 34'h0) begin
      bad++; $display("FAIL reset_idle_mem got=%b%b_%h want=0", bus.mem_write, bus.mem_read, bus.mem_address);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_read;
    apply_reset();
    set_b(1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    #1;
    total++; if ({bus.a_gnt, bus.b_gnt} !== 2'b01) begin bad++; $display("FAIL bwr_gnt got=%b%b want=01", bus.a_gnt, bus.b_gnt); end
    total++; if (bus.mem_write !== 1'b1 || bus.mem_address !== 32'h10 || bus.mem_wdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL bwr_mem got=%b %h %h want=1 10 deadbeef", bus.mem_write, bus.mem_address, bus.mem_wdata);
    end
    tick();
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set_a(1'b1, 1'b0, 32'h13, 32'h0);
    #1;
    total++; if (bus.a_gnt !== 1'b1) begin bad++; $display("FAIL ard_gnt got=%b want=1", bus.a_gnt); end
    total++; if (bus.mem_write !== 1'b0 || bus.mem_read !== 1'b1 || bus.mem_address !== 32'h13) begin
      bad++; $display("FAIL ard_mem got=%b%b %h want=01 13", bus.mem_write, bus.mem_read, bus.mem_address);
    end
    total++; if (bus.b_rvalid !== 1'b0) begin bad++; $display("FAIL bwr_no_rvalid got=%b want=0", bus.b_rvalid); end
    tick();
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    total++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ard_resp got=%b %h want=1 deadbeef", bus.a_rvalid, bus.a_rdata);
    end
    tick();
    total++; if (bus.a_rvalid !== 1'b0 || bus.a_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL ard_hold got=%b %h want=0 deadbeef", bus.a_rvalid, bus.a_rdata);
    end
  endtask

  task automatic test_alternate;
    logic [31:0] bw;
    logic [31:0] last;
    logic        exp_a;
    apply_reset();
    bw   = 32'h1111_0001;
    last = 32'h0;
    set_a(1'b1, 1'b0, 32'h20, 32'h0);
    set_b(1'b1, 1'b1, 32'h20, bw, 1'b0);
    for (int i = 0; i < 6; i++) begin
      #1;
      exp_a = (i % 2 == 0);
      total++; if ({bus.a_gnt, bus.b_gnt} !== {exp_a, ~exp_a}) begin
        bad++; $display("FAIL alt_gnt[%0d] got=%b%b want=%b%b", i, bus.a_gnt, bus.b_gnt, exp_a, ~exp_a);
      end
      tick();
      if (exp_a) begin
        total++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== last) begin
          bad++; $display("FAIL alt_rdata[%0d] got=%b %h want=1 %h", i, bus.a_rvalid, bus.a_rdata, last);
        end
      end else begin
        last = bw;
        bw   = bw + 32'h0101_0101;
        bus.b_wdata = bw;
      end
    end
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_lock;
    logic exp_a;
    apply_reset();
    set_a(1'b1, 1'b0, 32'h30, 32'h0);
    set_b(1'b1, 1'b1, 32'h40, 32'hCAFE0000, 1'b1);
    for (int i = 0; i < 21; i++) begin
      #1;
      exp_a = (i == 0) || (i == 17) || (i == 18);
      total++; if ({bus.a_gnt, bus.b_gnt} !== {exp_a, ~exp_a}) begin
        bad++; $display("FAIL lock_gnt[%0d] got=%b%b want=%b%b", i, bus.a_gnt, bus.b_gnt, exp_a, ~exp_a);
      end
      tick();
    end
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic test_out_of_range;
    apply_reset();
    set_b(1'b1, 1'b1, 32'h1000, 32'h12345678, 1'b0);
    #1;
    total++; if (bus.b_gnt !== 1'b1 || bus.mem_write !== 1'b0 || bus.mem_read !== 1'b0 || bus.mem_address !== 32'h1000) begin
      bad++; $display("FAIL oor_wr got=%b%b%b %h want=100 1000", bus.b_gnt, bus.mem_write, bus.mem_read, bus.mem_address);
    end
    tick();
    total++; if (bus.err !== 1'b1 || bus.b_rvalid !== 1'b0) begin
      bad++; $display("FAIL oor_wr_err got=%b%b want=10", bus.err, bus.b_rvalid);
    end
    set_b(1'b1, 1'b0, 32'h10, 32'h0, 1'b0);
    tick();
    total++; if (mem[0] !== 32'h0) begin bad++; $display("FAIL oor_mem0 got=%h want=0", mem[0]); end
    total++; if (bus.err !== 1'b0 || bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL brd_ok got=%b%b %h want=01 deadbeef", bus.err, bus.b_rvalid, bus.b_rdata);
    end
    set_b(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0);
    #1;
    total++; if (bus.b_gnt !== 1'b1 || bus.mem_read !== 1'b0) begin
      bad++; $display("FAIL oor_rd got=%b%b want=10", bus.b_gnt, bus.mem_read);
    end
    tick();
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    total++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'h0 || bus.err !== 1'b1) begin
      bad++; $display("FAIL oor_rd_resp got=%b %h %b want=1 0 1", bus.b_rvalid, bus.b_rdata, bus.err);
    end
    tick();
    total++; if (bus.err !== 1'b0 || bus.b_rvalid !== 1'b0) begin
      bad++; $display("FAIL oor_pulse got=%b%b want=00", bus.err, bus.b_rvalid);
    end
  endtask

  task automatic test_reset_mid_lock;
    apply_reset();
    set_a(1'b1, 1'b0, 32'h10, 32'h0);
    set_b(1'b1, 1'b0, 32'h10, 32'h0, 1'b1);
    repeat (17) tick();
    #1;
    total++; if (bus.a_gnt !== 1'b1 || bus.b_gnt !== 1'b0) begin
      bad++; $display("FAIL rml_release got=%b%b want=10", bus.a_gnt, bus.b_gnt);
    end
    total++; if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rml_b_resp got=%b %h want=1 deadbeef", bus.b_rvalid, bus.b_rdata);
    end
    rst = 1'b1;
    #1;
    total++; if (bus.b_rvalid !== 1'b0 || bus.b_rdata !== 32'h0 || bus.err !== 1'b0 || bus.a_rvalid !== 1'b0) begin
      bad++; $display("FAIL rml_async got=%b %h %b %b want=0 0 0 0", bus.b_rvalid, bus.b_rdata, bus.err, bus.a_rvalid);
    end
    tick();
    total++; if (bus.a_rvalid !== 1'b0) begin bad++; $display("FAIL rml_no_rvalid got=%b want=0", bus.a_rvalid); end
    rst = 1'b0;
    bus.b_lock = 1'b0;
    #1;
    total++; if ({bus.a_gnt, bus.b_gnt} !== 2'b10) begin
      bad++; $display("FAIL rml_first_tie got=%b%b want=10", bus.a_gnt, bus.b_gnt);
    end
    tick();
    total++; if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 32'hDEADBEEF) begin
      bad++; $display("FAIL rml_a_resp got=%b %h want=1 deadbeef", bus.a_rvalid, bus.a_rdata);
    end
    set_a(1'b0, 1'b0, 32'h0, 32'h0);
    set_b(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    test_reset();
    test_single_read();
    test_alternate();
    test_lock();
    test_out_of_range();
    test_reset_mid_lock();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
